// File: rtl/div_iter.sv
// Radix-2 restoring 32/32 divider (signed/unsigned), result {rem, quo}; 32 step cycles after acceptance, 2 for a zero divisor.
// Result is held while start_i stays high; flush/annul_i abort to idle on the next edge.
module div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        annul_i,
  input  logic        start_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic        ready_o,
  output logic [63:0] result_o
);

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BYZERO = 2'd1;
  localparam logic [1:0] S_ON     = 2'd2;
  localparam logic [1:0] S_END    = 2'd3;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic        neg_q;
  logic        neg_r;

  logic        cancel;
  logic        dvd_neg;
  logic        dvs_neg;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic        ge;
  logic [31:0] rem_step;
  logic [31:0] quo_step;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  always_comb begin
    cancel   = flush | annul_i;
    dvd_neg  = signed_div_i & opdata1_i[31];
    dvs_neg  = signed_div_i & opdata2_i[31];
    dvd_mag  = dvd_neg ? (32'd0 - opdata1_i) : opdata1_i;
    dvs_mag  = dvs_neg ? (32'd0 - opdata2_i) : opdata2_i;
    // Partial remainder is 33 bits after the shift; the difference always fits in 32 when it is taken.
    ge       = {rem, quo[31]} >= {1'b0, dvs};
    rem_step = ge ? ({rem[30:0], quo[31]} - dvs) : {rem[30:0], quo[31]};
    quo_step = {quo[30:0], ge};
    q_fix    = neg_q ? (32'd0 - quo_step) : quo_step;
    r_fix    = neg_r ? (32'd0 - rem_step) : rem_step;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FREE;
      cnt      <= 5'd0;
      rem      <= 32'd0;
      quo      <= 32'd0;
      dvs      <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      ready_o  <= 1'b0;
      result_o <= 64'd0;
    end else begin
      case (state)
        S_FREE: begin
          if (!cancel && start_i) begin
            cnt <= 5'd0;
            if (opdata2_i == 32'd0) begin
              state <= S_BYZERO;
            end else begin
              state <= S_ON;
              rem   <= 32'd0;
              quo   <= dvd_mag;
              dvs   <= dvs_mag;
              neg_q <= dvd_neg ^ dvs_neg;
              neg_r <= dvd_neg;
            end
          end
        end
        S_BYZERO: begin
          if (cancel) begin
            state <= S_FREE;
          end else if (cnt == 5'd0) begin
            cnt <= 5'd1;
          end else begin
            state    <= S_END;
            ready_o  <= 1'b1;
            result_o <= 64'd0;
          end
        end
        S_ON: begin
          if (cancel) begin
            state <= S_FREE;
          end else begin
            rem <= rem_step;
            quo <= quo_step;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state    <= S_END;
              ready_o  <= 1'b1;
              result_o <= {r_fix, q_fix};
            end
          end
        end
        default: begin
          if (cancel || !start_i) begin
            state    <= S_FREE;
            ready_o  <= 1'b0;
            result_o <= 64'd0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/div_iter.md
# div_iter

Multi-cycle radix-2 restoring divider for the execute stage, responding to the ALU's divide handshake. The ALU raises `start_i` with operands for DIV/DIVU and holds it until `ready_o`. The block then returns `{remainder, quotient}` for the HI/LO write. One bit of quotient is produced per cycle, and the operation can be cancelled by pipeline flush or annul.

## Interface
- No parameters; data width fixed at 32, result at 64.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  pipeline flush; abort any operation.
- `annul_i`  in  1  cancel request; same effect as `flush`.
- `start_i`  in  1  request; held high by the initiator until `ready_o` is seen.
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with the operands.
- `opdata1_i`  in  32  dividend; sampled at acceptance.
- `opdata2_i`  in  32  divisor; sampled at acceptance.
- `ready_o`  out  1  result valid; registered.
- `result_o`  out  64  `{remainder[31:0], quotient[31:0]}`; registered; zero when `ready_o`=0.

## Operation
- States: FREE, BYZERO, ON, END. After reset: FREE, `ready_o`=0, `result_o`=0, counter=0.
- **FREE** (acceptance edge), priority order:
  - `flush` or `annul_i` set: stay in FREE.
  - `start_i`=1 and `opdata2_i`==0: go to BYZERO.
  - `start_i`=1 and divisor nonzero: go to ON.
    - Capture the magnitudes of both operands. In signed mode use two's-complement negation when bit31 is set; 0x80000000 stays 0x80000000 as an unsigned magnitude.
    - Latch the quotient-negate flag (dividend sign XOR divisor sign, signed mode only) and the remainder-negate flag (dividend sign, signed mode only).
    - Load the working register {33'b0, |dividend|}; clear the counter.
- **ON**: each cycle is one restoring step.
  - Shift the working register left by 1.
  - Compute the trial difference = upper 33 bits − {1'b0, |divisor|}.
  - Non-negative: upper bits = difference, shifted-in bit = 1. Negative: keep the shifted value, shifted-in bit = 0.
  - Counter increments each step. On the 32nd step (counter 31):
    - Apply sign correction: negate the quotient if its flag is set; negate the remainder if its flag is set.
    - Register `result_o`, set `ready_o`=1, go to END.
- **BYZERO**: one cycle, then `result_o`=0, `ready_o`=1, go to END. Division by zero is architecturally undefined; the result is fixed at zero.
- **END**: `ready_o` and `result_o` are held while `start_i`=1. When `start_i`=0, the next edge clears `ready_o` and `result_o` and returns to FREE.
- Cancellation:
  - `flush` or `annul_i` in ON, BYZERO or END: next edge returns to FREE with `ready_o`=0 and `result_o`=0.
  - No partial result ever appears.
- `start_i` outside FREE is ignored. Operands are not re-sampled mid-operation, so input changes do not affect the result.
- Arithmetic: 32/32 → 32-bit quotient and remainder, truncating toward zero. Remainder has the dividend's sign. Signed 0x80000000 / 0xFFFFFFFF wraps to quotient 0x80000000, remainder 0.
- `rst` overrides all inputs.

## Timing
- Define acceptance edge A as the first edge in FREE with `start_i`=1 and no cancel.
- Nonzero divisor:
  - Steps occur at edges A+1..A+32.
  - `ready_o`=1 and `result_o` valid in the cycle after edge A+32, i.e. 32 cycles after the acceptance cycle.
- Zero divisor: `ready_o`=1 after edge A+2.
- `start_i` drops in cycle C: `ready_o`=0 after edge C+1, and FREE is reached at that edge.
- Back-to-back: a new `start_i` can be accepted at edge C+2 at the earliest.
- Cancel in cycle X: FREE and `ready_o`=0 after edge X+1.
- `ready_o` never glitches; it is only driven from the state register.

## Test plan
- **Unsigned:** `opdata1_i`=100, `opdata2_i`=7, `signed_div_i`=0, hold start.
  - `ready_o` rises exactly 32 cycles after acceptance.
  - `result_o`=0x00000002_0000000E.
- **Signed:** −7 / 2 (0xFFFFFFF9 / 0x00000002).
  - `result_o`=0xFFFFFFFF_FFFFFFFD.
  - Also check 7 / −2: `result_o`=0x00000001_FFFFFFFD.
- **Overflow corner:**
  - Signed 0x80000000 / 0xFFFFFFFF → 0x00000000_80000000.
  - Unsigned same operands → 0x80000000_00000000.
- **Zero divisor:** 1234 / 0.
  - `ready_o`=1 two cycles after acceptance, `result_o`=0.
  - Then drop start: `ready_o`=0 one cycle later.
- **Flush mid-divide:** assert `flush` for one cycle at step 10.
  - `ready_o` stays 0; block returns to FREE.
  - A following 100/7 completes correctly in 32 cycles.
- **Hold/release and reset:**
  - Keep `start_i` high for 5 cycles after `ready_o`: result held stable.
  - Assert `rst` during ON: `ready_o`=0, `result_o`=0, FREE next cycle.
